// File: rtl/imem_loader.sv
// Loads a program from a UART byte stream into byte-addressed instruction memory,
// big-endian, until a word-aligned HALT word arrives or the memory fills up.
module imem_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_rx_valid,
    input  logic [7:0]        i_rx_data,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-2:0] o_prog_len
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;
    localparam logic [ADDR_W-2:0] LEN_ONE  = 1;

    state_t            state_reg, state_next;
    logic              start_q_reg, start_prev_reg;
    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [23:0]       shift_reg, shift_next;
    logic [ADDR_W-2:0] len_reg, len_next;
    logic              we_reg, we_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [7:0]        data_reg, data_next;
    logic              done_reg, done_next;

    logic        start_rise;
    logic [31:0] word;
    logic        word_end;
    logic        halt_hit;

    // i_start is registered before edge detection so no input reaches state combinationally
    assign start_rise = start_q_reg & ~start_prev_reg;
    assign word       = {shift_reg, i_rx_data};
    assign word_end   = (ptr_reg[1:0] == 2'd3);
    assign halt_hit   = word_end && (word == HALT_WORD);

    // State register and all datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            start_q_reg    <= 1'b0;
            start_prev_reg <= 1'b0;
            ptr_reg        <= '0;
            shift_reg      <= '0;
            len_reg        <= '0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            data_reg       <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            start_q_reg    <= i_start;
            start_prev_reg <= start_q_reg;
            ptr_reg        <= ptr_next;
            shift_reg      <= shift_next;
            len_reg        <= len_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            data_reg       <= data_next;
            done_reg       <= done_next;
        end
    end

    // Next-state logic; HALT takes priority over overflow on the final address
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (start_rise) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    if (halt_hit)                  state_next = ST_IDLE;
                    else if (ptr_reg == PTR_LAST)  state_next = ST_ERR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        ptr_next   = ptr_reg;
        shift_next = shift_reg;
        len_next   = len_reg;
        we_next    = 1'b0;
        addr_next  = addr_reg;
        data_next  = data_reg;
        done_next  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_ERR: begin
                if (start_rise) begin
                    ptr_next   = '0;
                    shift_next = '0;
                    len_next   = '0;
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    we_next    = 1'b1;
                    addr_next  = ptr_reg;
                    data_next  = i_rx_data;
                    ptr_next   = ptr_reg + PTR_ONE;
                    shift_next = word[23:0];
                    if (word_end) len_next = len_reg + LEN_ONE;
                    done_next  = halt_hit;
                end
            end
            default: ;
        endcase
    end

    assign o_mem_we   = we_reg;
    assign o_mem_addr = addr_reg;
    assign o_mem_data = data_reg;
    assign o_busy     = (state_reg == ST_LOAD);
    assign o_done     = done_reg;
    assign o_err      = (state_reg == ST_ERR);
    assign o_prog_len = len_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 16-byte memory so overflow is reachable.
module tb_imem_loader;

    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              i_start = 1'b0;
    logic              i_rx_valid = 1'b0;
    logic [7:0]        i_rx_data = 8'h00;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        o_mem_data;
    logic              o_busy;
    logic              o_done;
    logic              o_err;
    logic [ADDR_W-2:0] o_prog_len;

    int n_checks = 0;
    int n_fails  = 0;

    imem_loader #(.ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_start    (i_start),
        .i_rx_valid (i_rx_valid),
        .i_rx_data  (i_rx_data),
        .o_mem_we   (o_mem_we),
        .o_mem_addr (o_mem_addr),
        .o_mem_data (o_mem_data),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_prog_len (o_prog_len)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte; the write must appear right after the capturing edge
    task automatic send(input logic [7:0] b, input int ea, input bit edone, input bit eerr);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        @(posedge clk); #1;
        check("we", {31'd0, o_mem_we}, 32'd1);
        check("addr", {28'd0, o_mem_addr}, ea[31:0]);
        check("data", {24'd0, o_mem_data}, {24'd0, b});
        check("done", {31'd0, o_done}, {31'd0, edone});
        check("err", {31'd0, o_err}, {31'd0, eerr});
        $display("byte %02h -> addr %0d done=%0b err=%0b len=%0d", b, o_mem_addr, o_done, o_err, o_prog_len);
    endtask

    task automatic gap(input int n);
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("we_gap", {31'd0, o_mem_we}, 32'd0);
            check("done_gap", {31'd0, o_done}, 32'd0);
        end
    endtask

    // Raise i_start; busy must follow one cycle after the sampling edge
    task automatic start_load();
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk); #1;
        check("busy_lat", {31'd0, o_busy}, 32'd0);
        @(posedge clk); #1;
        check("busy_start", {31'd0, o_busy}, 32'd1);
        check("len_start", {29'd0, o_prog_len}, 32'd0);
        check("err_start", {31'd0, o_err}, 32'd0);
        $display("start: busy=%0b len=%0d err=%0b", o_busy, o_prog_len, o_err);
    endtask

    logic [7:0] jr [16];
    logic [7:0] bb [12];

    initial begin
        jr = '{8'h3C, 8'h0B, 8'h00, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h01, 8'h60, 8'h00, 8'h08, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        bb = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
               8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Reset with random inputs
        repeat (5) begin
            @(negedge clk);
            i_start    = 1'($urandom);
            i_rx_valid = 1'($urandom);
            i_rx_data  = 8'($urandom);
            #1;
            check("rst_outs", {o_mem_we, o_busy, o_done, o_err, 8'd0, o_mem_data, 4'd0, o_mem_addr, 5'd0, o_prog_len}, 32'd0);
        end
        $display("reset: outputs all zero checked");
        @(negedge clk);
        i_start = 1'b0; i_rx_valid = 1'b0; rst = 1'b1;
        repeat (2) @(posedge clk);

        // Bytes in IDLE are ignored
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i_rx_valid = 1'b1;
            i_rx_data  = 8'(8'h10 + i);
            @(posedge clk); #1;
            check("idle_we", {31'd0, o_mem_we}, 32'd0);
            check("idle_busy", {31'd0, o_busy}, 32'd0);
        end
        $display("idle: bytes ignored");
        gap(1);

        // JR program with 3-cycle gaps
        start_load();
        i_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(jr[i], i, i == 15, 1'b0);
            gap(3);
        end
        check("jr_len", {29'd0, o_prog_len}, 32'd4);
        check("jr_busy", {31'd0, o_busy}, 32'd0);
        $display("jr: len=%0d busy=%0b", o_prog_len, o_busy);

        // Back-to-back with FF bytes straddling word boundaries
        start_load();
        i_start = 1'b0;
        for (int i = 0; i < 12; i++) send(bb[i], i, i == 11, 1'b0);
        gap(1);
        check("bb_len", {29'd0, o_prog_len}, 32'd3);
        check("bb_busy", {31'd0, o_busy}, 32'd0);
        $display("b2b: len=%0d busy=%0b", o_prog_len, o_busy);

        // Overflow: 16 zero bytes fill memory without HALT
        start_load();
        i_start = 1'b0;
        for (int i = 0; i < 16; i++) send(8'h00, i, 1'b0, i == 15);
        gap(1);
        check("ovf_busy", {31'd0, o_busy}, 32'd0);
        check("ovf_len", {29'd0, o_prog_len}, 32'd4);
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h5A;
        @(posedge clk); #1;
        check("ovf_17_we", {31'd0, o_mem_we}, 32'd0);
        check("ovf_17_err", {31'd0, o_err}, 32'd1);
        $display("overflow: 17th byte we=%0b err=%0b", o_mem_we, o_err);
        gap(1);
        start_load();
        i_start = 1'b0;
        send(8'hAB, 0, 1'b0, 1'b0);

        // Reset mid-load after 6 bytes
        for (int i = 1; i < 6; i++) send(8'(8'h20 + i), i, 1'b0, 1'b0);
        @(negedge clk);
        i_rx_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_we", {31'd0, o_mem_we}, 32'd0);
        check("mid_rst_len", {29'd0, o_prog_len}, 32'd0);
        check("mid_rst_addr", {28'd0, o_mem_addr}, 32'd0);
        $display("mid-load reset: busy=%0b we=%0b", o_busy, o_mem_we);
        @(negedge clk);
        rst = 1'b1;
        start_load();
        i_start = 1'b0;
        send(8'h00, 0, 1'b0, 1'b0);
        send(8'h01, 1, 1'b0, 1'b0);
        send(8'h02, 2, 1'b0, 1'b0);
        send(8'h03, 3, 1'b0, 1'b0);
        for (int i = 4; i < 8; i++) send(8'hFF, i, i == 7, 1'b0);
        gap(1);
        check("rst_len", {29'd0, o_prog_len}, 32'd2);

        // i_start held high through a load: no restart, one done
        start_load();
        for (int i = 0; i < 4; i++) send(8'hFF, i, i == 3, 1'b0);
        gap(4);
        check("held_busy", {31'd0, o_busy}, 32'd0);
        check("held_len", {29'd0, o_prog_len}, 32'd1);
        $display("held start: busy=%0b len=%0d", o_busy, o_prog_len);
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) @(posedge clk);
        start_load();
        i_start = 1'b0;
        send(8'h77, 0, 1'b0, 1'b0);
        gap(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the instruction-fetch stage's instruction memory. While the debug unit is in its LOAD state, it receives the program as a UART byte stream. It writes the bytes big-endian, one byte per address, into the byte-addressed instruction memory: word 0xAABBCCDD lands as AA at addr 0, DD at addr 3. A word of 0xFFFFFFFF (HALT) terminates the load, after which the debug unit may switch the pipeline to RUN.

## Interface
Parameters:
- ADDR_W, 8, instruction-memory byte address width; capacity 2^ADDR_W bytes.
- HALT_WORD, 32'hFFFFFFFF, end-of-program marker; it is also written to memory.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_start  in  1  level from debug unit; rising edge seen in IDLE or ERR starts a load.
- i_rx_valid  in  1  one-cycle strobe, received UART byte valid.
- i_rx_data  in  8  received byte.
- o_mem_we  out  1  instruction-memory byte write enable.
- o_mem_addr  out  ADDR_W  write byte address.
- o_mem_data  out  8  write byte.
- o_busy  out  1  high in LOAD.
- o_done  out  1  one-cycle pulse when HALT word completes.
- o_err  out  1  sticky overflow flag (memory full without HALT).
- o_prog_len  out  ADDR_W-1  words loaded including HALT; held until next start.

## Operation
- States:
  - IDLE, LOAD, ERR.
  - Reset enters IDLE with address pointer 0, byte shift register 0, o_prog_len 0, and all outputs 0.
- IDLE:
  - i_rx_valid is ignored.
  - A rising edge of i_start (registered previous-value detect) moves to LOAD and clears the pointer, o_prog_len and o_err.
- LOAD:
  - Each i_rx_valid byte is captured into the output registers: o_mem_addr = pointer, o_mem_data = byte, o_mem_we = 1 for one cycle.
  - The pointer then increments; it wraps at 2^ADDR_W.
  - The byte is also shifted into the 32-bit word assembler, MSB first.
  - When pointer[1:0]==3 at capture, the assembled word is complete and o_prog_len increments.
  - If the completed word == HALT_WORD, go to IDLE and pulse o_done.
  - Else, if pointer == 2^ADDR_W−1, go to ERR. The last byte is still written.
  - Else stay in LOAD.
- HALT is recognised only on word-aligned boundaries. FF bytes that straddle a word boundary are not HALT.
- ERR:
  - o_err = 1, no writes, i_rx_valid ignored.
  - A rising edge of i_start restarts LOAD exactly as from IDLE.
- i_start edges during LOAD are ignored; the load continues.
- A byte arriving every cycle (back-to-back i_rx_valid) must be accepted without loss.
- Reset mid-load: immediate return to IDLE with all outputs 0. Already written memory bytes are not cleared.

## Timing
- Byte accepted at edge N (i_rx_valid=1 before N): o_mem_we, o_mem_addr and o_mem_data are valid during cycle N..N+1 and deassert at edge N+1 unless another byte arrives.
- Completing the HALT 4th byte at edge N: the final write and the o_done pulse are in the same cycle; o_busy drops at edge N; o_prog_len is updated at edge N.
- Overflow at edge N: the last write and o_err both rise at edge N.
- i_start rising edge sampled at edge N: o_busy = 1 from edge N+1 (one-cycle edge-detect latency).
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Reset:** hold rst=0 with random inputs → all outputs 0. Release, send bytes without i_start → no o_mem_we.
- **JR program:** pulse i_start, then send 3C 0B 00 F0 00 00 00 00 01 60 00 08 FF FF FF FF with 3-cycle gaps → 16 writes to addr 0..15 with matching data; o_done on the last write; o_prog_len=4; o_busy=0 afterwards.
- **Back-to-back and straddling FF:** send 00 FF FF FF, then FF 00 00 00, then FF FF FF FF with i_rx_valid high every cycle → all 12 bytes written, no early done, o_done on addr 11, o_prog_len=3.
- **Overflow (ADDR_W=4):** send 16 bytes of 0x00 → writes to addr 0..15, o_err=1 at the 16th write, no o_done. A 17th byte causes no write. A new i_start edge clears o_err and reloads from addr 0.
- **Reset mid-load:** after 6 bytes, pull rst low for 1 cycle → o_busy=0, o_mem_we=0. A new start begins at addr 0 with o_prog_len=0.
- **i_start held high through a load:** start a load, keep i_start high, send HALT → no restart; o_done pulses once. Toggling i_start low then high starts a second load at addr 0.
